// File: rtl/tick_ctrl_pkg.sv
// tick_ctrl_pkg: shared constants and the state encoding for the tick controller.
//   WIDTH_DEF         default counter / terminal-count width
//   DEFAULT_COUNT_DEF terminal count loaded at reset
//   state_t           controller states (IDLE, RUN, SHOT)
package tick_ctrl_pkg;

  localparam int WIDTH_DEF         = 24;
  localparam int DEFAULT_COUNT_DEF = 13_500;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SHOT = 2'd2
  } state_t;

endpackage

// File: rtl/tick_ctrl_if.sv
// tick_ctrl_if: control/config and output bundle of the tick controller.
//   cfg_valid/cfg_count/cfg_ready  terminal-count load handshake
//   start/stop/oneshot             run control requests
//   tick/clk_out/busy/done         controller outputs
// master = requester side, slave = tick_ctrl side.
interface tick_ctrl_if
  import tick_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_count;
  logic             cfg_ready;
  logic             start;
  logic             stop;
  logic             oneshot;
  logic             tick;
  logic             clk_out;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_count, start, stop, oneshot,
    input  cfg_ready, tick, clk_out, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_count, start, stop, oneshot,
    output cfg_ready, tick, clk_out, busy, done
  );
endinterface

// File: rtl/tick_counter.sv
// tick_counter: period counter of the tick controller.
//   clk_in, rst_n  clock, async active-low reset
//   en             count enable (controller busy); counter held at 0 otherwise
//   clr            synchronous clear (stop request)
//   term           active terminal count
//   tc             combinational terminal-count strobe for this cycle
//   tick           registered one-cycle pulse, follows tc by one edge
module tick_counter
  import tick_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic             tc,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;

  assign tc = en && (cnt == term);

  // A stop coinciding with terminal count still issues the tick.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= tc;
      if (!en || clr || tc) cnt <= '0;
      else                  cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/tick_ctrl.sv
// tick_ctrl: sequencer for a programmable clock divider.
//   clk_in, rst_n  clock, async active-low reset
//   bus (slave)    cfg handshake, start/stop/oneshot in; tick, clk_out, busy, done out
// Terminal count written in IDLE goes straight to the active register; while
// busy it is staged in a shadow register and applied at the next terminal
// count (or on return to IDLE), holding cfg_ready low meanwhile.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | counter held at 0, config writes active count
// ST_RUN  | free-running, tick every active+1 cycles
// ST_SHOT | single period, then back to IDLE with done
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int DEFAULT_COUNT = DEFAULT_COUNT_DEF
) (
  input  logic       clk_in,
  input  logic       rst_n,
  tick_ctrl_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] active_cnt;
  logic [WIDTH-1:0] shadow_cnt;
  logic             pending;
  logic             pending_nxt;
  logic             tc;
  logic             accept;
  logic             cnt_en;
  logic             to_idle;

  assign accept  = bus.cfg_valid & bus.cfg_ready;
  assign cnt_en  = (state != ST_IDLE);
  assign to_idle = cnt_en && (bus.stop || (tc && (state == ST_SHOT)));

  tick_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (cnt_en),
    .clr    (bus.stop),
    .term   (active_cnt),
    .tc     (tc),
    .tick   (bus.tick)
  );

  // A write accepted on a terminal-count cycle stays pending until the
  // following boundary; leaving for IDLE always flushes the shadow.
  always_comb begin
    pending_nxt = pending;
    if ((state == ST_IDLE) || to_idle) begin
      pending_nxt = 1'b0;
    end else begin
      if (tc)     pending_nxt = 1'b0;
      if (accept) pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      active_cnt    <= WIDTH'(DEFAULT_COUNT);
      shadow_cnt    <= WIDTH'(DEFAULT_COUNT);
      pending       <= 1'b0;
      bus.clk_out   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.cfg_ready <= 1'b0;
    end else begin
      bus.done      <= tc && (state == ST_SHOT);
      pending       <= pending_nxt;
      bus.cfg_ready <= ~pending_nxt;
      if (tc) bus.clk_out <= ~bus.clk_out;

      case (state)
        ST_IDLE: begin
          if (accept) active_cnt <= bus.cfg_count;
          if (bus.start && !bus.stop) begin
            state    <= bus.oneshot ? ST_SHOT : ST_RUN;
            bus.busy <= 1'b1;
          end
        end
        ST_RUN, ST_SHOT: begin
          if (to_idle) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
            if (accept)       active_cnt <= bus.cfg_count;
            else if (pending) active_cnt <= shadow_cnt;
          end else begin
            if (tc && pending) active_cnt <= shadow_cnt;
            if (accept)        shadow_cnt <= bus.cfg_count;
          end
        end
        default: begin
          state    <= ST_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_ctrl.sv
// tb_tick_ctrl: scoreboard bench for tick_ctrl. Episodes compute the edge
// numbers of every expected tick arithmetically (start edge + k*(count+1),
// switching period after the first boundary following a reconfig) and push
// them into a queue; an independent monitor pops on every observed tick.
module tb_tick_ctrl;
  import tick_ctrl_pkg::*;

  localparam int W = 24;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;

  tick_ctrl_if #(.WIDTH(W)) bus ();

  tick_ctrl #(.WIDTH(W), .DEFAULT_COUNT(13_500)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int t;
    bit ck;
    bit dn;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_active;
  bit   m_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, expv);
    end
  endtask

  task automatic push(input int t, input bit dn);
    m_clk = ~m_clk;
    sbq.push_back('{t: t, ck: m_clk, dn: dn});
  endtask

  // monitor
  always @(posedge clk_in) begin
    #1;
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].t < cyc) begin
        e = sbq.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_tick: expected at cycle %0d, still absent at %0d", e.t, cyc);
      end
      if (bus.done === 1'b1 && bus.tick !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL done_without_tick at cycle %0d: tick %b", cyc, bus.tick);
      end
      if (bus.tick === 1'b1) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_tick at cycle %0d: no tick expected", cyc);
        end else begin
          e = sbq.pop_front();
          chk("tick_cycle", 64'(cyc), 64'(e.t));
          chk("clk_out", bus.clk_out, e.ck);
          chk("done", bus.done, e.dn);
        end
      end
    end
  end

  task automatic cfg_idle(input int c);
    int n = 0;
    @(negedge clk_in);
    while (bus.cfg_ready !== 1'b1 && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_valid = 1'b1;
    bus.cfg_count = W'(c);
    @(negedge clk_in);
    bus.cfg_valid = 1'b0;
    m_active = c;
  endtask

  // One start..halt episode from IDLE. wr_off>0 writes new_c at edge start+wr_off.
  task automatic episode(input bit do_cfg, input int c, input bit shot, input int dur,
                         input int wr_off, input int new_c);
    int s, fin, w, tt, per, k;
    bit applied;
    if (do_cfg) cfg_idle(c);
    else        c = m_active;
    @(negedge clk_in);
    bus.start   = 1'b1;
    bus.oneshot = shot;
    s = cyc + 1;
    w = -1;
    if (shot) begin
      fin = s + 1 + c;
      push(fin, 1'b1);
    end else begin
      fin = s + dur;
      if (wr_off > 0) w = s + wr_off;
      per = c + 1;
      applied = 1'b0;
      tt = s;
      while (1) begin
        tt += per;
        if (tt > fin) break;
        push(tt, 1'b0);
        if (w >= 0 && !applied && tt > w) begin
          per = new_c + 1;
          applied = 1'b1;
        end
      end
    end
    while (cyc < fin + 2) begin
      @(negedge clk_in);
      k = cyc;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      if (k == s) chk("busy_after_start", bus.busy, 1);
      if (!shot) begin
        if (k == s + 1 && dur >= 4) begin
          bus.start   = 1'b1;
          bus.oneshot = 1'b1;
        end
        if (w >= 0 && k == w - 1) begin
          bus.cfg_valid = 1'b1;
          bus.cfg_count = W'(new_c);
        end
        if (w >= 0 && k == w) begin
          bus.cfg_valid = 1'b0;
          chk("cfg_ready_pending", bus.cfg_ready, 0);
        end
        if (k == fin - 1) bus.stop = 1'b1;
      end
      if (k == fin) chk("busy_after_halt", bus.busy, 0);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    if (w >= 0) m_active = new_c;
    chk("cfg_ready_end", bus.cfg_ready, 1);
  endtask

  task automatic start_stop_idle();
    @(negedge clk_in);
    bus.start   = 1'b1;
    bus.stop    = 1'b1;
    bus.oneshot = 1'b0;
    @(negedge clk_in);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("busy_start_stop", bus.busy, 0);
    repeat (5) @(negedge clk_in);
    chk("busy_start_stop_later", bus.busy, 0);
  endtask

  task automatic reset_mid_period();
    int s, r;
    cfg_idle(4);
    @(negedge clk_in);
    bus.start   = 1'b1;
    bus.oneshot = 1'b0;
    s = cyc + 1;
    r = s + 5;
    push(r, 1'b0);
    if (!m_clk) begin
      r = s + 10;
      push(r, 1'b0);
    end
    while (cyc < r + 2) begin
      @(negedge clk_in);
      bus.start = 1'b0;
    end
    chk("clk_out_before_reset", bus.clk_out, 1);
    chk("busy_before_reset", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_tick", bus.tick, 0);
    chk("rst_clk_out", bus.clk_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_queue_drained", 64'(sbq.size()), 0);
    m_clk    = 1'b0;
    m_active = 13_500;
    @(negedge clk_in);
    rst_n = 1'b1;
    @(negedge clk_in);
    chk("cfg_ready_after_reset", bus.cfg_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, d, wo, nc;
    bit sh;
    bus.cfg_valid = 1'b0;
    bus.cfg_count = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.oneshot   = 1'b0;
    m_clk    = 1'b0;
    m_active = 13_500;
    repeat (3) @(negedge clk_in);
    chk("reset_tick", bus.tick, 0);
    chk("reset_clk_out", bus.clk_out, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    rst_n = 1'b1;
    @(negedge clk_in);
    chk("reset_cfg_ready", bus.cfg_ready, 1);

    episode(1'b1, 3, 1'b0, 12, 0, 0);   // ticks at +4,+8,+12; stop on last tick
    episode(1'b1, 0, 1'b0, 6, 0, 0);    // tick every cycle
    episode(1'b1, 5, 1'b1, 0, 0, 0);    // one-shot, tick+done at +6
    episode(1'b1, 9, 1'b0, 40, 4, 2);   // 10-cycle period, then 3-cycle periods
    start_stop_idle();
    episode(1'b1, 2, 1'b0, 9, 0, 0);    // restart from 0
    episode(1'b0, 0, 1'b0, 7, 3, 1);    // write on a terminal-count edge

    for (int i = 0; i < 25; i++) begin
      c  = $urandom_range(0, 7);
      sh = ($urandom_range(0, 3) == 0);
      d  = $urandom_range(3, 40);
      wo = 0;
      nc = $urandom_range(0, 7);
      if (!sh && $urandom_range(0, 1) == 1) wo = $urandom_range(1, d - 1);
      episode($urandom_range(0, 3) != 0, c, sh, d, wo, nc);
    end

    reset_mid_period();
    episode(1'b0, 0, 1'b1, 0, 0, 0);    // default count one-shot after reset

    repeat (5) @(negedge clk_in);
    chk("scoreboard_empty", 64'(sbq.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tick_ctrl.md
# tick_ctrl

Controller that sequences a programmable clock-divider counter: loads the terminal count through a valid/ready handshake, starts and stops division, and supports free-running and one-shot modes. It emits a one-cycle `tick` enable and a divided square wave `clk_out`. It sits between control logic (switch/FSM front ends) and timed consumers such as display scanners and debouncers, replacing fixed-count dividers wherever the rate must change at run time.

## Interface
- `WIDTH`, 24: counter and terminal-count width.
- `DEFAULT_COUNT`, 13_500: terminal count loaded at reset.

- `clk_in` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: new terminal count offered.
- `cfg_count` in WIDTH: terminal count; the tick period is `cfg_count`+1 cycles.
- `cfg_ready` out 1: controller accepts `cfg_count` this cycle.
- `start` in 1: one-cycle start request.
- `stop` in 1: one-cycle stop request.
- `oneshot` in 1: sampled with `start`; 1 = emit a single tick then halt.
- `tick` out 1: one-cycle pulse at terminal count.
- `clk_out` out 1: toggles on every tick (period 2·(count+1)).
- `busy` out 1: high in RUN or SHOT.
- `done` out 1: one-cycle pulse when a one-shot completes.

## Operation
- States: IDLE, RUN, SHOT.
- Reset (async, `rst_n`=0): state IDLE, counter 0, active count = shadow count = DEFAULT_COUNT, pending flag 0, `tick`=0, `clk_out`=0, `busy`=0, `done`=0. `cfg_ready`=1 once out of reset.
- IDLE: counter held at 0, `clk_out` holds its value. `cfg_valid`&`cfg_ready` writes the active count directly. `start` → RUN (`oneshot`=0) or SHOT (`oneshot`=1); the counter begins at 0 on the next cycle.
- RUN/SHOT: the counter increments each cycle. When counter == active count: `tick`=1, `clk_out` toggles, counter ← 0.
- RUN: repeat indefinitely. SHOT: after the first tick → IDLE and `done`=1 in the same cycle as `tick`.
- Config while busy: `cfg_valid`&`cfg_ready` writes the shadow register and sets pending. `cfg_ready`=0 while pending. At the next terminal count, active ← shadow and pending clears. The current period finishes with the old count.
- `stop` in RUN/SHOT → IDLE next cycle and the counter clears. A pending config is applied on entry to IDLE.
- Arithmetic: unsigned compare. A count of 0 gives a tick every cycle, with `clk_out` = clk_in/2.
- If the active count is lowered below the current counter value, this cannot occur, because changes apply only at the boundary.

## Timing
- `start` at cycle N: the first `tick` occurs at cycle N+1+count. Subsequent ticks occur every count+1 cycles.
- `tick`, `clk_out`, `done`, `busy`, `cfg_ready` are all registered outputs; there are no combinational paths from inputs.
- `stop` and terminal count in the same cycle: the tick is still issued and `clk_out` toggles, then IDLE. In SHOT, `done` is also asserted.
- `start` while busy is ignored. `start` and `stop` together in IDLE: `stop` wins, and the state stays IDLE.
- `cfg_valid` with `cfg_ready`=0: the value is ignored. The requester must hold `cfg_valid` until the handshake completes.
- Config handshake in the same cycle as a terminal count: the new value goes to the shadow register and applies at the next boundary, not the current one.
- `rst_n` asserted mid-period: all outputs go to reset values immediately; the partial period is discarded.

## Structure
- Package `tick_ctrl_pkg`: state encoding (IDLE=2'd0, RUN=2'd1, SHOT=2'd2) and the default WIDTH/DEFAULT_COUNT constants.
- Sub-module `tick_counter`: handles enable, clear, the compare against the active count, and the `tick` output. `tick_ctrl` owns the FSM, the shadow/pending logic, and the `clk_out` toggle.

## Test plan
- Reset, then `start` with count 3 and `oneshot`=0: ticks at cycles N+4, N+8, N+12; `clk_out` toggles at each tick.
- Count 0, RUN: `tick` is high every cycle and `clk_out` toggles every cycle.
- `oneshot`=1, count 5: a single `tick` with `done` at N+6, then `busy`=0 and the counter stays at 0.
- In RUN with count 9, write 2 mid-period: `cfg_ready` drops, the current period stays 10 cycles, then periods become 3 cycles and `cfg_ready` returns high.
- `stop` coincident with terminal count: `tick` is seen once and the state becomes IDLE; a later `start` restarts from 0.
- Assert `rst_n` mid-period with `clk_out`=1: outputs clear asynchronously, and the active count returns to 13_500.
